// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller that drives an external dual-port RAM. It keeps the
// wrap-bit pointers, the EMPTY/PARTIAL/FULL state, the sticky error flags and a registered read word.
module fifo_ctrl #(
   parameter int DATA_RAM_WIDTH    = 8,
   parameter int ADDR_WIDTH        = 8,
   parameter int ALMOST_FULL_LEVEL = 2**ADDR_WIDTH - 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      push_valid,
   output logic                      push_ready,
   input  logic [DATA_RAM_WIDTH-1:0] push_data,
   input  logic                      pop_valid,
   output logic                      pop_ready,
   output logic [DATA_RAM_WIDTH-1:0] pop_data,
   output logic                      pop_data_valid,
   output logic [ADDR_WIDTH-1:0]     ram_address_0,
   output logic                      ram_chip_enable_0,
   output logic                      ram_write_read_0,
   output logic [DATA_RAM_WIDTH-1:0] ram_data_0,
   output logic [ADDR_WIDTH-1:0]     ram_address_1,
   output logic                      ram_chip_enable_1,
   output logic                      ram_write_read_1,
   input  logic [DATA_RAM_WIDTH-1:0] ram_data_1,
   output logic                      ram_full,
   output logic [ADDR_WIDTH:0]       count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_full,
   output logic                      overflow,
   output logic                      underflow
);
   // state      | meaning
   // ST_EMPTY   | no words stored, pops refused
   // ST_PARTIAL | 1..DEPTH-1 words stored
   // ST_FULL    | DEPTH words stored, pushes refused
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

   logic [1:0]          state, state_nxt;
   logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
   logic                push_acc, pop_acc;

   assign count       = wr_ptr - rd_ptr;
   assign empty       = (state == ST_EMPTY);
   assign full        = (state == ST_FULL);
   assign almost_full = (count >= AF_LEVEL);
   assign ram_full    = full;
   assign push_ready  = !full;
   assign pop_ready   = !empty;

   // Reset and clear suppress both handshakes so the RAM is never touched in those cycles.
   assign push_acc = push_valid && push_ready && !clear && !rst;
   assign pop_acc  = pop_valid && pop_ready && !clear && !rst;

   assign ram_chip_enable_0 = push_acc;
   assign ram_write_read_0  = push_acc;
   assign ram_address_0     = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_data_0        = push_data;
   assign ram_chip_enable_1 = pop_acc;
   assign ram_write_read_1  = 1'b0;
   assign ram_address_1     = rd_ptr[ADDR_WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY:   if (push_acc) state_nxt = ST_PARTIAL;
         ST_PARTIAL: begin
            if (push_acc && !pop_acc && count == DEPTH_M1)
               state_nxt = ST_FULL;
            else if (pop_acc && !push_acc && count == CNT_ONE)
               state_nxt = ST_EMPTY;
         end
         ST_FULL:    if (pop_acc) state_nxt = ST_PARTIAL;
         default:    state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_EMPTY;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         pop_data       <= '0;
         pop_data_valid <= 1'b0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         overflow  <= overflow  | (push_valid && full);
         underflow <= underflow | (pop_valid && empty);
         if (clear) begin
            state          <= ST_EMPTY;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pop_data_valid <= 1'b0;
         end else begin
            state          <= state_nxt;
            pop_data_valid <= pop_acc;
            if (push_acc) wr_ptr <= wr_ptr + CNT_ONE;
            if (pop_acc) begin
               rd_ptr   <= rd_ptr + CNT_ONE;
               pop_data <= ram_data_1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl at DEPTH=4: directed scenarios followed by random traffic, all
// compared against a queue-based reference model and a small behavioural RAM.
module tb_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst, clear, push_valid, pop_valid;
   logic [DW-1:0] push_data;
   logic          push_ready, pop_ready, pop_data_valid;
   logic [DW-1:0] pop_data, ram_data_0, ram_data_1;
   logic [AW-1:0] ram_address_0, ram_address_1;
   logic          ram_chip_enable_0, ram_write_read_0, ram_chip_enable_1, ram_write_read_1;
   logic          ram_full, empty, full, almost_full, overflow, underflow;
   logic [AW:0]   count;

   always #5 clk = ~clk;

   fifo_ctrl #(.DATA_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .pop_data_valid(pop_data_valid),
      .ram_address_0(ram_address_0), .ram_chip_enable_0(ram_chip_enable_0),
      .ram_write_read_0(ram_write_read_0), .ram_data_0(ram_data_0),
      .ram_address_1(ram_address_1), .ram_chip_enable_1(ram_chip_enable_1),
      .ram_write_read_1(ram_write_read_1), .ram_data_1(ram_data_1),
      .ram_full(ram_full), .count(count), .empty(empty), .full(full),
      .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
   );

   logic [DW-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   always @(posedge clk)
      if (ram_chip_enable_0 && ram_write_read_0) mem[ram_address_0] <= ram_data_0;
   assign ram_data_1 = mem[ram_address_1];

   // Reference model
   logic [DW-1:0] q[$];
   int            wr_n, rd_n;
   bit            m_ovf, m_unf, m_pdv;
   logic [DW-1:0] m_pdata;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit clr, input bit pv, input logic [DW-1:0] pd,
                       input bit qv);
      int  sz;
      bit  m_full, m_empty, pacc, qacc;
      @(negedge clk);
      rst = r; clear = clr; push_valid = pv; push_data = pd; pop_valid = qv;
      #1;
      sz = q.size();
      m_full  = (sz == DEPTH);
      m_empty = (sz == 0);
      pacc = pv && !m_full && !clr && !r;
      qacc = qv && !m_empty && !clr && !r;
      chk("count", 32'(count), 32'(sz));
      chk("empty", 32'(empty), 32'(m_empty));
      chk("full", 32'(full), 32'(m_full));
      chk("almost_full", 32'(almost_full), 32'(sz >= 2));
      chk("ram_full", 32'(ram_full), 32'(m_full));
      chk("push_ready", 32'(push_ready), 32'(!m_full));
      chk("pop_ready", 32'(pop_ready), 32'(!m_empty));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("pop_data_valid", 32'(pop_data_valid), 32'(m_pdv));
      chk("pop_data", 32'(pop_data), 32'(m_pdata));
      chk("wr_ptr", 32'(dut.wr_ptr), 32'(wr_n % (2*DEPTH)));
      chk("rd_ptr", 32'(dut.rd_ptr), 32'(rd_n % (2*DEPTH)));
      chk("ram_ce0", 32'(ram_chip_enable_0), 32'(pacc));
      chk("ram_wr0", 32'(ram_write_read_0), 32'(pacc));
      chk("ram_ce1", 32'(ram_chip_enable_1), 32'(qacc));
      chk("ram_wr1", 32'(ram_write_read_1), 32'd0);
      if (pacc) begin
         chk("ram_addr0", 32'(ram_address_0), 32'(wr_n % DEPTH));
         chk("ram_data0", 32'(ram_data_0), 32'(pd));
      end
      if (qacc) chk("ram_addr1", 32'(ram_address_1), 32'(rd_n % DEPTH));
      @(posedge clk);
      if (r) begin
         q.delete(); wr_n = 0; rd_n = 0;
         m_ovf = 0; m_unf = 0; m_pdv = 0; m_pdata = '0;
      end else begin
         if (pv && m_full) m_ovf = 1;
         if (qv && m_empty) m_unf = 1;
         if (clr) begin
            q.delete(); wr_n = 0; rd_n = 0; m_pdv = 0;
         end else begin
            m_pdv = qacc;
            if (qacc) begin m_pdata = q.pop_front(); rd_n++; end
            if (pacc) begin q.push_back(pd); wr_n++; end
         end
      end
   endtask

   logic [DW-1:0] fill_vals [4];

   initial begin
      rst = 1; clear = 0; push_valid = 0; pop_valid = 0; push_data = '0;
      q.delete(); wr_n = 0; rd_n = 0; m_ovf = 0; m_unf = 0; m_pdv = 0; m_pdata = '0;
      @(posedge clk);
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      // fill, overflow, drain, underflow
      fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
      for (int i = 0; i < 4; i++) step(0, 0, 1, fill_vals[i], 0);
      step(0, 0, 1, 8'h55, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 0);
      // overflow and underflow survive clear
      step(0, 1, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      // wrap: interleaved push/pop
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 8'(8'h60 + i), 0);
         step(0, 0, 0, 8'h00, 1);
      end
      // simultaneous at count 2, then at full
      step(0, 0, 1, 8'h01, 0);
      step(0, 0, 1, 8'h02, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hAA, 1);
      step(0, 0, 1, 8'h03, 0);
      step(0, 0, 1, 8'h04, 0);
      step(0, 0, 1, 8'hBB, 1);
      step(0, 0, 1, 8'hCC, 0);
      step(0, 0, 0, 8'h00, 0);
      // clear mid-stream at count 3
      step(0, 0, 0, 8'h00, 1);
      step(0, 1, 1, 8'hEE, 1);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 1, 8'h71, 0);
      step(0, 0, 1, 8'h72, 0);
      step(1, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step(0, 0, 0, 8'h00, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
